// File: rtl/power_sched.sv
// power_sched: shared x^e mod 256 engine with round-robin request arbitration.
// Optional POWER_SCHED_BYPASS_EN: exponents 0 and 1 resolve directly in EVAL.
module power_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int EXP_W   = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_arstn,
  input  logic [NUM_REQ-1:0]       i_reqValid,
  input  logic [8*NUM_REQ-1:0]     i_reqX,
  input  logic [EXP_W*NUM_REQ-1:0] i_reqExp,
  output logic [NUM_REQ-1:0]       o_reqReady,
  output logic                     o_rspValid,
  output logic [7:0]               o_rspData,
  output logic [IDW-1:0]           o_rspId,
  input  logic                     i_rspReady
);

  localparam logic [IDW:0]   NUM_REQ_V = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EVAL = 3'd1,
    S_MULR = 3'd2,
    S_SQR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       r_q, r_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       ph_q, ph_d;
  logic [7:0]       opa_q, opa_d;
  logic [7:0]       opb_q, opb_d;
  logic [7:0]       pp_bd_q, pp_bd_d;
  logic [7:0]       pp_ad_q, pp_ad_d;
  logic [7:0]       pp_bc_q, pp_bc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
`ifdef POWER_SCHED_BYPASS_EN
  logic             byp_q, byp_d;
`endif

  logic               gnt_found_s;
  logic [IDW-1:0]     gnt_idx_s;
  logic [IDW:0]       cand_s;
  logic [IDW:0]       sum_s;
  logic               hit_s;
  logic [NUM_REQ-1:0] gnt_oh_s;
  logic [7:0]         x_sel_s;
  logic [EXP_W-1:0]   exp_sel_s;
  logic [7:0]         mid_s;
  logic [7:0]         prod_s;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    sum_s       = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s       = {1'b0, ptr_q} + (IDW+1)'(k);
      cand_s      = (sum_s >= NUM_REQ_V) ? (sum_s - NUM_REQ_V) : sum_s;
      hit_s       = !gnt_found_s && i_reqValid[cand_s[IDW-1:0]];
      gnt_idx_s   = hit_s ? cand_s[IDW-1:0] : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_s;
    end
  end

  // Operand select for the granted requester and the grant vector.
  always_comb begin
    x_sel_s   = '0;
    exp_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      x_sel_s   = (gnt_idx_s == IDW'(i)) ? i_reqX[8*i +: 8] : x_sel_s;
      exp_sel_s = (gnt_idx_s == IDW'(i)) ? i_reqExp[EXP_W*i +: EXP_W] : exp_sel_s;
    end
    gnt_oh_s   = gnt_found_s ? (NUM_REQ'(1) << gnt_idx_s) : '0;
    o_reqReady = ((state_q == S_IDLE) && i_arstn) ? gnt_oh_s : '0;
  end

  // A*C is omitted: it only contributes to bits 8 and above.
  assign mid_s  = pp_ad_q + pp_bc_q;
  assign prod_s = pp_bd_q + (mid_s << 4);

  assign o_rspValid = rsp_valid_q;
  assign o_rspData  = rsp_data_q;
  assign o_rspId    = rsp_id_q;

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    b_d         = b_q;
    r_d         = r_q;
    e_d         = e_q;
    id_d        = id_q;
    ph_d        = ph_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    pp_bd_d     = pp_bd_q;
    pp_ad_d     = pp_ad_q;
    pp_bc_d     = pp_bc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
`ifdef POWER_SCHED_BYPASS_EN
    byp_d       = byp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          b_d     = x_sel_s;
          r_d     = 8'h01;
          e_d     = exp_sel_s;
          id_d    = gnt_idx_s;
          ptr_d   = (gnt_idx_s == LAST_ID) ? '0 : (gnt_idx_s + IDW'(1));
          ph_d    = 2'd0;
`ifdef POWER_SCHED_BYPASS_EN
          byp_d   = ({1'b0, exp_sel_s} < (EXP_W+1)'(2));
`endif
          state_d = S_EVAL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        ph_d = 2'd0;
        if (e_q == '0) begin
          state_d = S_DONE;
        end else if (e_q[0]) begin
`ifdef POWER_SCHED_BYPASS_EN
          if (byp_q) begin
            r_d     = b_q;
            e_d     = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_MULR;
          end
`else
          state_d = S_MULR;
`endif
        end else begin
          state_d = S_SQR;
        end
      end
      S_MULR, S_SQR: begin
        case (ph_q)
          2'd0: begin
            opa_d = (state_q == S_MULR) ? r_q : b_q;
            opb_d = b_q;
            ph_d  = 2'd1;
          end
          2'd1: begin
            pp_bd_d = {4'h0, opa_q[3:0]} * {4'h0, opb_q[3:0]};
            pp_ad_d = {4'h0, opa_q[7:4]} * {4'h0, opb_q[3:0]};
            pp_bc_d = {4'h0, opa_q[3:0]} * {4'h0, opb_q[7:4]};
            ph_d    = 2'd2;
          end
          default: begin
            if (state_q == S_MULR) begin
              r_d = prod_s;
              e_d = e_q & ~(EXP_W'(1));
            end else begin
              b_d = prod_s;
              e_d = e_q >> 1;
            end
            ph_d    = 2'd0;
            state_d = S_EVAL;
          end
        endcase
      end
      S_DONE: begin
        // First DONE cycle loads the response; it then holds until accepted.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = r_q;
          rsp_id_d    = id_q;
        end else if (i_rspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      b_q         <= 8'h00;
      r_q         <= 8'h00;
      e_q         <= '0;
      id_q        <= '0;
      ph_q        <= 2'd0;
      opa_q       <= 8'h00;
      opb_q       <= 8'h00;
      pp_bd_q     <= 8'h00;
      pp_ad_q     <= 8'h00;
      pp_bc_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_id_q    <= '0;
`ifdef POWER_SCHED_BYPASS_EN
      byp_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      b_q         <= b_d;
      r_q         <= r_d;
      e_q         <= e_d;
      id_q        <= id_d;
      ph_q        <= ph_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      pp_bd_q     <= pp_bd_d;
      pp_ad_q     <= pp_ad_d;
      pp_bc_q     <= pp_bc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
`ifdef POWER_SCHED_BYPASS_EN
      byp_q       <= byp_d;
`endif
    end
  end

endmodule

// File: tb/tb_power_sched.sv
// Directed bench for power_sched with a cycle-level reference model of
// arbitration, response timing and x^e mod 256.
module tb_power_sched;

  logic        clk;
  logic        arstn;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [15:0] req_exp;
  logic        rsp_ready;
  logic [3:0]  o_reqReady;
  logic        o_rspValid;
  logic [7:0]  o_rspData;
  logic [1:0]  o_rspId;

  int total;
  int bad;

  power_sched dut (
    .i_clk      (clk),
    .i_arstn    (arstn),
    .i_reqValid (req_valid),
    .i_reqX     (req_x),
    .i_reqExp   (req_exp),
    .o_reqReady (o_reqReady),
    .o_rspValid (o_rspValid),
    .o_rspData  (o_rspData),
    .o_rspId    (o_rspId),
    .i_rspReady (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] pow_ref(input logic [7:0] x, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = r * x;
    return r;
  endfunction

  function automatic int lat_ref(input int e);
    int m;
    int msb;
    m = 0;
    msb = 0;
    if (e == 0) return 2;
`ifdef POWER_SCHED_BYPASS_EN
    if (e == 1) return 2;
`endif
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        m++;
        msb = i;
      end
    end
    return 2 + 4 * (m + msb);
  endfunction

  // Reference model: compared against the DUT on every falling edge.
  initial begin : monitor
    bit         busy;
    bit         rsp_on;
    bit         found;
    int         k;
    int         lat;
    int         ptr;
    int         m_id;
    int         c;
    logic [7:0] m_data;
    logic [3:0] exp_rdy;
    busy = 1'b0;
    k = 0;
    lat = 0;
    ptr = 0;
    m_id = 0;
    m_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        chk("mon_rst_ready", 32'(o_reqReady), 0);
        chk("mon_rst_valid", 32'(o_rspValid), 0);
        chk("mon_rst_data", 32'(o_rspData), 0);
        chk("mon_rst_id", 32'(o_rspId), 0);
        busy = 1'b0;
        k = 0;
        ptr = 0;
      end else begin
        exp_rdy = 4'b0000;
        found = 1'b0;
        if (!busy) begin
          for (int j = 0; j < 4; j++) begin
            c = (ptr + j) % 4;
            if (!found && req_valid[c]) begin
              found = 1'b1;
              exp_rdy[c] = 1'b1;
              m_id = c;
            end
          end
        end
        chk("mon_ready", 32'(o_reqReady), 32'(exp_rdy));
        rsp_on = busy && (k >= lat);
        chk("mon_valid", 32'(o_rspValid), 32'(rsp_on));
        if (rsp_on) begin
          chk("mon_data", 32'(o_rspData), 32'(m_data));
          chk("mon_id", 32'(o_rspId), m_id);
        end
        if (found) begin
          busy = 1'b1;
          k = 0;
          lat = lat_ref(int'(req_exp[m_id*4 +: 4]));
          m_data = pow_ref(req_x[m_id*8 +: 8], int'(req_exp[m_id*4 +: 4]));
          ptr = (m_id + 1) % 4;
        end else if (busy) begin
          if (rsp_on && rsp_ready) busy = 1'b0;
          else k++;
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [7:0] x, input logic [3:0] e);
    req_x[id*8 +: 8]   = x;
    req_exp[id*4 +: 4] = e;
    req_valid[id]      = 1'b1;
  endtask

  task automatic grant_drop(input int id, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (o_reqReady[id]) got = 1'b1;
    end
    chk({nm, "_grant"}, 32'(got), 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input logic [7:0] d, input int id, input int lat, input string nm);
    bit got;
    int c;
    got = 1'b0;
    c = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (o_rspValid) got = 1'b1;
      else c++;
    end
    chk({nm, "_seen"}, 32'(got), 1);
    chk({nm, "_data"}, 32'(o_rspData), 32'(d));
    chk({nm, "_id"}, 32'(o_rspId), id);
    chk({nm, "_lat"}, c, lat);
    if (rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_job(input int id, input logic [7:0] x, input logic [3:0] e,
                         input logic [7:0] d, input int lat, input string nm);
    set_req(id, x, e);
    grant_drop(id, nm);
    wait_rsp(d, id, lat, nm);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gq[5];
    int exp_g[5];
    int ng;
    int nr;
    total = 0;
    bad = 0;
    arstn = 1'b0;
    req_valid = 4'b0000;
    req_x = 32'h0;
    req_exp = 16'h0;
    rsp_ready = 1'b1;
    exp_g = '{0, 1, 2, 3, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("init_ready", 32'(o_reqReady), 0);
    chk("init_valid", 32'(o_rspValid), 0);
    chk("init_data", 32'(o_rspData), 0);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // All four requesters contend continuously.
    for (int j = 0; j < 4; j++) set_req(j, 8'(j + 1), 4'd2);
    ng = 0;
    nr = 0;
    for (int n = 0; n < 400 && ng < 5; n++) begin
      @(negedge clk);
      if (o_rspValid && nr < 5) begin
        chk("arb_rsp_id", 32'(o_rspId), gq[nr]);
        nr++;
      end
      if (o_reqReady != 4'b0000) begin
        for (int j = 0; j < 4; j++) if (o_reqReady[j]) gq[ng] = j;
        ng++;
      end
    end
    chk("arb_grants", ng, 5);
    for (int j = 0; j < 5; j++) chk("arb_order", gq[j], exp_g[j]);
    chk("arb_rsp_count", nr, 4);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_rsp(8'h01, 0, 10, "arb5");

    run_job(0, 8'h03, 4'd3, 8'h1B, 14, "p3e3");
    run_job(0, 8'h03, 4'd5, 8'hF3, 18, "p3e5");
    run_job(0, 8'h02, 4'd8, 8'h00, 18, "p2e8");
    run_job(2, 8'hFF, 4'd15, 8'hFF, 30, "pffe15");
    run_job(0, 8'h10, 4'd2, 8'h00, 10, "p10e2");
    run_job(0, 8'h00, 4'd0, 8'h01, 2, "p0e0");
`ifdef POWER_SCHED_BYPASS_EN
    run_job(0, 8'h5A, 4'd1, 8'h5A, 2, "p5ae1");
`else
    run_job(0, 8'h5A, 4'd1, 8'h5A, 6, "p5ae1");
`endif

    // Response back-pressure with a competing requester waiting.
    rsp_ready = 1'b0;
    set_req(1, 8'h07, 4'd2);
    grant_drop(1, "stall");
    set_req(3, 8'h0B, 4'd1);
    wait_rsp(8'h31, 1, 10, "stall");
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_valid", 32'(o_rspValid), 1);
      chk("stall_data", 32'(o_rspData), 32'h31);
      chk("stall_id", 32'(o_rspId), 1);
      chk("stall_nogrant", 32'(o_reqReady), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_nogrant", 32'(o_reqReady), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hs_next_grant", 32'(o_reqReady), 32'h8);
    chk("hs_next_valid", 32'(o_rspValid), 0);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_rsp(8'h0B, 3, lat_ref(1), "after_stall");

    // Reset while a multiply is in flight.
    set_req(2, 8'h03, 4'd3);
    grant_drop(2, "rst_job");
    set_req(0, 8'h02, 4'd3);
    set_req(3, 8'h05, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    chk("rst_ready", 32'(o_reqReady), 0);
    chk("rst_valid", 32'(o_rspValid), 0);
    chk("rst_data", 32'(o_rspData), 0);
    chk("rst_id", 32'(o_rspId), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", 32'(o_reqReady), 32'h1);
    chk("rst_no_stale", 32'(o_rspValid), 0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_rsp(8'h08, 0, 14, "post_rst0");
    grant_drop(3, "post_rst3");
    wait_rsp(8'h19, 3, 10, "post_rst3");
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_sched.md
Name: power_sched

Overview:
- Shared modular-power engine: computes x^e mod 256 for NUM_REQ requesters through one internal 8x8 nibble-partial-product multiplier.
- Right-to-left square-and-multiply, one multiply in flight at a time.
- Round-robin arbitration between requesters; results return on a single valid/ready response channel tagged with the requester ID.
- Sits in front of the power-pipeline datapath as its sequencer and arbiter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- EXP_W, 4, exponent width; legal range 1..8.
- IDW, $clog2(NUM_REQ), requester ID width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_arstn  in  1  asynchronous active-low reset.
- i_reqValid  in  NUM_REQ  per-requester request valid.
- i_reqX  in  8*NUM_REQ  base operand; requester i uses bits [8i+7:8i].
- i_reqExp  in  EXP_W*NUM_REQ  exponent; requester i uses bits [EXP_W*i+EXP_W-1:EXP_W*i].
- o_reqReady  out  NUM_REQ  grant, one-hot or zero.
- o_rspValid  out  1  result valid.
- o_rspData  out  8  result, x^e mod 256.
- o_rspId  out  IDW  index of the requester that owns the result.
- i_rspReady  in  1  response accept.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; o_reqReady=0, o_rspValid=0, o_rspData=0, o_rspId=0.
  - Round-robin pointer=0; all internal registers=0.
  - Reset mid-operation discards the job; no response is produced for it.
- Registers: base b, result r, remaining exponent e, id, multiply phase counter.
- States:
  - IDLE:
    - o_reqReady has a combinational single bit set: the first valid requester at or after the pointer, searching upward and wrapping.
    - Handshake on valid&ready: latch b=x, r=1, e=exp, id. Pointer becomes id+1 mod NUM_REQ. Next state EVAL.
    - No grant in any other state.
  - EVAL (1 cycle): e==0 -> DONE; e[0]==1 -> MULR; otherwise -> SQR.
  - MULR (3 cycles):
    - Computes r*b. On the third cycle r gets the product and e[0] is cleared.
    - Next state EVAL.
  - SQR (3 cycles):
    - Computes b*b. On the third cycle b gets the product and e is shifted right by 1.
    - Next state EVAL.
  - DONE:
    - o_rspValid=1, o_rspData=r, o_rspId=id.
    - Outputs held stable while i_rspReady=0.
    - On valid&ready, o_rspValid falls next cycle and state returns to IDLE.
    - A new grant is issued one cycle after the response handshake, never in the same cycle.
- Multiplier, 3-cycle fixed latency, results truncated to 8 bits:
  - Cycle 1: register operands (A|B) and (C|D), nibbles with MS nibble first.
  - Cycle 2: register 8-bit partial products B*D, A*D and B*C. A*C is never formed because it only affects bits 8 and above.
  - Cycle 3: capture (B*D + ((A*D + B*C) << 4)) mod 256.
  - All wrap-around is modulo 256; no overflow flag.
- Latency:
  - Counted from the request handshake edge to the first cycle o_rspValid=1.
  - L = 2 + 4*M, where M = popcount(exp) + index of the MSB of exp (M=0 for exp=0).
  - The result does not depend on the requester or on arbitration history.
- Simultaneous requests: exactly one is granted per job. Losers keep i_reqValid high and are served in round-robin order.
- Request inputs are sampled only at the handshake; changes during a job are ignored.

Optional Feature:
- Macro: POWER_SCHED_BYPASS_EN.
- Defined: in EVAL, if the original exponent was 0 or 1, r is loaded with 1 or x respectively and the state goes straight to DONE. Latency is 2 for both cases.
- Undefined: exp=1 takes the normal path (one MULR, latency 6). exp=0 latency is 2 in both builds.

Test Plan:
- Reset with i_arstn pulsed low mid-MULR -> all outputs 0 immediately. After release, no stale response; next grant goes to requester 0.
- Req0 x=3 exp=3 -> rspData=0x1B, id=0, latency 14. Req0 x=3 exp=5 -> 0xF3, latency 18.
- Wrap-around:
  - x=2 exp=8 -> 0x00.
  - x=0xFF exp=15 -> 0xFF.
  - x=0x10 exp=2 -> 0x00.
  - x=0 exp=0 -> 0x01, latency 2.
- All 4 requesters valid continuously with distinct x, exp=2 -> grants in order 0,1,2,3,0.
  - Each o_rspId matches its grant.
  - o_reqReady is never asserted outside IDLE.
- i_rspReady held 0 for 10 cycles in DONE -> o_rspValid, o_rspData and o_rspId stable and no new grant. Grant follows one cycle after the handshake.
- exp=1, x=0x5A:
  - With POWER_SCHED_BYPASS_EN: 0x5A at latency 2.
  - Without it: 0x5A at latency 6.
